urf_scheduler: RTL and testbench

- Round-robin sequencer for NUM_URF ultrasonic range finder channels sharing one airframe.
- Fires exactly one sensor at a time, with an enforced quiet gap between firings, to prevent acoustic crosstalk.
- Captures each channel's 10-bit range and valid flag into a holding register, flags per-channel timeouts, and gives the flight logic one coherent range bank plus a new-data strobe.
- Runs on the 1 MHz microsecond clock; one cycle = 1 us.

---
 rtl/urf_scheduler.sv | 153 +++++++++++++++
 tb/tb_urf_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/urf_scheduler.sv
`timescale 1ns/1ps
// urf_scheduler
// Round-robin sequencer for NUM_URF ultrasonic range finders sharing one
// airframe. Only one sensor is fired at a time, and a quiet gap separates
// the end of one measurement from the next trigger so that echoes cannot
// cross between channels. Each channel's result is kept in a holding bank
// that the flight logic reads as one coherent set.
// One us_clk cycle is one microsecond.
//
// Ports
//   us_clk         1 MHz clock
//   resetn         synchronous active-low reset
//   enable         run the schedule while high (checked only in IDLE/ADVANCE)
//   err_clear      one-cycle pulse, clears all timeout_err bits
//   urf_complete   per-channel measurement-complete pulse
//   urf_valid      per-channel range-valid level
//   urf_range_bus  channel k range in bits [k*RANGE_W +: RANGE_W]
//   urf_start      one-hot, one-cycle trigger to the scheduled channel
//   range_out      captured ranges, same packing as urf_range_bus
//   range_valid    per-channel validity of range_out
//   timeout_err    sticky per-channel timeout flags
//   new_data       one-cycle pulse when a channel slot resolves
//   cur_channel    index of the channel currently scheduled
//   busy           high in every state except IDLE
//   sched_debug    {9'd0, one-hot state}
//
// Interface timing: there is no valid/ready handshake. urf_start and
// new_data are single-cycle pulses; urf_complete is sampled only for the
// scheduled channel and only while waiting for that channel; urf_valid and
// the range slice are sampled in the cycle after the complete pulse, so a
// sensor must hold them for at least that cycle.
module urf_scheduler #(
    parameter int NUM_URF    = 3,
    parameter int GAP_US     = 10000,
    parameter int TIMEOUT_US = 30000,
    parameter int RANGE_W    = 10
) (
    input  logic                       us_clk,
    input  logic                       resetn,
    input  logic                       enable,
    input  logic                       err_clear,
    input  logic [NUM_URF-1:0]         urf_complete,
    input  logic [NUM_URF-1:0]         urf_valid,
    input  logic [NUM_URF*RANGE_W-1:0] urf_range_bus,
    output logic [NUM_URF-1:0]         urf_start,
    output logic [NUM_URF*RANGE_W-1:0] range_out,
    output logic [NUM_URF-1:0]         range_valid,
    output logic [NUM_URF-1:0]         timeout_err,
    output logic                       new_data,
    output logic [2:0]                 cur_channel,
    output logic                       busy,
    output logic [15:0]                sched_debug
);

    typedef enum logic [6:0] {
        S_IDLE    = 7'b0000001,
        S_GAP     = 7'b0000010,
        S_START   = 7'b0000100,
        S_WAIT    = 7'b0001000,
        S_CAPTURE = 7'b0010000,
        S_TIMEOUT = 7'b0100000,
        S_ADVANCE = 7'b1000000
    } state_t;

    localparam logic [17:0] TIMER_MAX = '1;
    localparam logic [17:0] GAP_LAST  = 18'(GAP_US - 1);
    localparam logic [17:0] TO_LAST   = 18'(TIMEOUT_US - 1);
    localparam logic [2:0]  LAST_CH   = 3'(NUM_URF - 1);

    state_t               state;
    state_t               state_next;
    logic [17:0]          timer;
    logic                 timer_clear;
    logic [NUM_URF-1:0]   sel;
    logic                 sel_complete;

    // One-hot mask of the scheduled channel; every per-channel access goes
    // through it, so stray bits of other channels can never act.
    assign sel          = {{(NUM_URF-1){1'b0}}, 1'b1} << cur_channel;
    assign sel_complete = |(urf_complete & sel);

    assign sched_debug  = {9'd0, state};

    // Timer restarts only when GAP or START is freshly entered.
    assign timer_clear = (state_next != state) &&
                         ((state_next == S_GAP) || (state_next == S_START));

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:    if (enable) state_next = S_GAP;
            S_GAP:     if (timer == GAP_LAST) state_next = S_START;
            S_START:   state_next = S_WAIT;
            S_WAIT: begin
                // A complete arriving on the last allowed cycle still wins.
                if (sel_complete)          state_next = S_CAPTURE;
                else if (timer == TO_LAST) state_next = S_TIMEOUT;
            end
            S_CAPTURE: state_next = S_ADVANCE;
            S_TIMEOUT: state_next = S_ADVANCE;
            S_ADVANCE: state_next = enable ? S_GAP : S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge us_clk) begin
        if (!resetn) begin
            state <= S_IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            if (timer_clear)             timer <= '0;
            else if (timer != TIMER_MAX) timer <= timer + 18'd1;
        end
    end

    // Pulse outputs are decoded from the next state so they are high
    // exactly while the FSM sits in START, CAPTURE or TIMEOUT.
    always_ff @(posedge us_clk) begin
        if (!resetn) begin
            urf_start   <= '0;
            new_data    <= 1'b0;
            busy        <= 1'b0;
            cur_channel <= 3'd0;
            range_out   <= '0;
            range_valid <= '0;
            timeout_err <= '0;
        end else begin
            urf_start <= (state_next == S_START) ? sel : '0;
            new_data  <= (state_next == S_CAPTURE) || (state_next == S_TIMEOUT);
            busy      <= (state_next != S_IDLE);

            if (state == S_ADVANCE)
                cur_channel <= (cur_channel == LAST_CH) ? 3'd0 : cur_channel + 3'd1;

            if (state == S_CAPTURE) begin
                // Invalid result keeps the old range but marks it stale.
                range_valid <= (range_valid & ~sel) | (urf_valid & sel);
                for (int k = 0; k < NUM_URF; k++) begin
                    if (sel[k] && urf_valid[k])
                        range_out[k*RANGE_W +: RANGE_W] <= urf_range_bus[k*RANGE_W +: RANGE_W];
                end
            end else if (state == S_TIMEOUT) begin
                range_valid <= range_valid & ~sel;
            end

            // A timeout set in the same cycle as err_clear survives.
            timeout_err <= (err_clear ? '0 : timeout_err) |
                           ((state == S_TIMEOUT) ? sel : '0);
        end
    end

endmodule

// File: tb/tb_urf_scheduler.sv
`timescale 1ns/1ps
// Self-checking bench for urf_scheduler with NUM_URF=3, GAP_US=5,
// TIMEOUT_US=20. Inputs are driven and outputs sampled on the falling edge.
// The reference model tracks the expected holding bank, error flags and
// scheduled channel per slot, and the expected cycle at which each trigger
// and each new_data pulse must appear.
module tb_urf_scheduler;
    localparam int N  = 3;
    localparam int GP = 5;
    localparam int TO = 20;
    localparam int RW = 10;

    logic            us_clk = 1'b0;
    logic            resetn;
    logic            enable;
    logic            err_clear;
    logic [N-1:0]    urf_complete;
    logic [N-1:0]    urf_valid;
    logic [N*RW-1:0] urf_range_bus;
    logic [N-1:0]    urf_start;
    logic [N*RW-1:0] range_out;
    logic [N-1:0]    range_valid;
    logic [N-1:0]    timeout_err;
    logic            new_data;
    logic [2:0]      cur_channel;
    logic            busy;
    logic [15:0]     sched_debug;

    int n_checks = 0;
    int n_fail   = 0;

    logic [RW-1:0] exp_range [N];
    logic [N-1:0]  exp_valid;
    logic [N-1:0]  exp_err;
    int            exp_chan;
    int            next_wait;

    urf_scheduler #(.NUM_URF(N), .GAP_US(GP), .TIMEOUT_US(TO), .RANGE_W(RW)) dut (
        .us_clk(us_clk), .resetn(resetn), .enable(enable), .err_clear(err_clear),
        .urf_complete(urf_complete), .urf_valid(urf_valid),
        .urf_range_bus(urf_range_bus), .urf_start(urf_start),
        .range_out(range_out), .range_valid(range_valid),
        .timeout_err(timeout_err), .new_data(new_data),
        .cur_channel(cur_channel), .busy(busy), .sched_debug(sched_debug)
    );

    // Clock / watchdog
    always #5 us_clk = ~us_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge us_clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*RW-1:0] model_bank();
        logic [N*RW-1:0] p;
        p = '0;
        for (int k = 0; k < N; k++) p[k*RW +: RW] = exp_range[k];
        return p;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) exp_range[k] = '0;
        exp_valid = '0;
        exp_err   = '0;
        exp_chan  = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"},   urf_start,   0);
        check({tag, "_range"},   range_out,   0);
        check({tag, "_valid"},   range_valid, 0);
        check({tag, "_err"},     timeout_err, 0);
        check({tag, "_newdata"}, new_data,    0);
        check({tag, "_busy"},    busy,        0);
        check({tag, "_chan"},    cur_channel, 0);
        check({tag, "_state"},   sched_debug, 16'h0001);
    endtask

    // One channel slot: wait for the trigger, answer after d cycles (d >= TO
    // means never answer), then check the bank once the channel advances.
    task automatic run_slot(input int wait_n, input int d, input bit v,
                            input logic [RW-1:0] r, input int stray_j,
                            input bit clr, input int drop_j);
        logic [N-1:0] sel;
        logic [N-1:0] stray;
        int  ch;
        int  k;
        int  nd_j;
        bit  seen;
        bit  timed_out;

        ch        = exp_chan;
        sel       = 3'b001 << ch;
        stray     = 3'b001 << ((ch + 1) % N);
        timed_out = (d >= TO);
        nd_j      = timed_out ? TO : d + 1;

        seen = 0;
        k    = 0;
        while (!seen && k < wait_n + 4) begin
            tick();
            k++;
            if (urf_start != '0) seen = 1;
        end
        check("start_latency", k, wait_n);
        if (!seen) return;
        check("start_onehot", urf_start, sel);
        check("start_chan", cur_channel, ch);
        check("start_busy", busy, 1);

        // Unrelated slices carry junk to expose any cross-channel capture.
        urf_range_bus              = N*RW'($urandom);
        urf_valid                  = N'($urandom);
        urf_range_bus[ch*RW +: RW] = r;
        urf_valid[ch]              = v;

        for (int j = 1; j <= nd_j; j++) begin
            tick();
            urf_complete = '0;
            err_clear    = 1'b0;
            if (j == 1) check("start_width", urf_start, 0);
            check("new_data_timing", new_data, (j == nd_j));
            if (!timed_out && j == d) urf_complete = sel;
            if (j == stray_j)         urf_complete = urf_complete | stray;
            if (j == drop_j)          enable = 1'b0;
            if (j == nd_j && clr)     err_clear = 1'b1;
        end

        if (timed_out) begin
            exp_valid[ch] = 1'b0;
        end else begin
            exp_valid[ch] = v;
            if (v) exp_range[ch] = r;
        end
        exp_err = (clr ? '0 : exp_err) | (timed_out ? sel : '0);

        tick();
        urf_complete = '0;
        err_clear    = 1'b0;
        check("new_data_width", new_data, 0);

        tick();
        exp_chan = (exp_chan + 1) % N;
        check("bank_range", range_out, model_bank());
        check("bank_valid", range_valid, exp_valid);
        check("timeout_err", timeout_err, exp_err);
        check("next_chan", cur_channel, exp_chan);
        check("busy_after", busy, enable);
        check("state_after", sched_debug, enable ? 16'h0002 : 16'h0001);
    endtask

    initial begin
        int d;
        int sj;
        int k;

        // Reset
        resetn        = 1'b0;
        enable        = 1'b0;
        err_clear     = 1'b0;
        urf_complete  = '0;
        urf_valid     = '0;
        urf_range_bus = '0;
        model_reset();
        repeat (3) tick();
        check_reset_outputs("reset");
        resetn = 1'b1;
        tick();
        check("idle_busy", busy, 0);
        check("idle_state", sched_debug, 16'h0001);

        // First trigger and first capture
        enable = 1'b1;
        run_slot(GP + 1, 8, 1'b1, 10'd123, 0, 1'b0, 0);

        // Full rotation
        run_slot(GP, $urandom_range(1, TO - 1), 1'b1, 10'd200, 0, 1'b0, 0);
        run_slot(GP, $urandom_range(1, TO - 1), 1'b1, 10'd401, 0, 1'b0, 0);
        check("rotation_pack", range_out, {10'd401, 10'd200, 10'd123});
        check("rotation_valid", range_valid, 3'b111);
        run_slot(GP, $urandom_range(1, TO - 1), 1'b1, RW'($urandom), 0, 1'b0, 0);

        // Channel 1 never completes
        run_slot(GP, TO + 5, 1'b1, RW'($urandom), 0, 1'b0, 0);
        check("to_err", timeout_err, 3'b010);
        check("to_valid1", range_valid[1], 0);
        check("to_slice1", range_out[19:10], 10'd200);

        // Channel 2 invalid, with a stray channel 0 complete before it
        run_slot(GP, $urandom_range(4, TO - 1), 1'b0, RW'($urandom), 2, 1'b0, 0);
        check("inv_valid2", range_valid[2], 0);
        check("inv_slice2", range_out[29:20], 10'd401);

        // Complete on the last allowed cycle
        run_slot(GP, TO - 1, 1'b1, RW'($urandom), 0, 1'b0, 0);
        check("edge_no_err", timeout_err, 3'b010);
        run_slot(GP, $urandom_range(1, TO - 1), 1'b1, RW'($urandom), 0, 1'b0, 0);
        run_slot(GP, $urandom_range(1, TO - 1), 1'b1, RW'($urandom), 0, 1'b0, 0);

        // err_clear in the same cycle as a channel 0 timeout
        run_slot(GP, TO + 10, 1'b1, RW'($urandom), 0, 1'b1, 0);
        check("clr_set_wins", timeout_err, 3'b001);

        // enable dropped mid-measurement, then restarted from IDLE
        run_slot(GP, 10, 1'b1, RW'($urandom), 0, 1'b0, 4);
        check("drop_idle_busy", busy, 0);
        enable = 1'b1;
        run_slot(GP + 1, $urandom_range(1, TO - 1), 1'b1, RW'($urandom), 0, 1'b0, 0);

        // Randomized slots
        next_wait = GP;
        for (int n = 0; n < 12; n++) begin
            d  = $urandom_range(1, TO + 4);
            sj = (d > 2 && d < TO) ? $urandom_range(1, d - 1) : 0;
            run_slot(next_wait, d, 1'($urandom), RW'($urandom), sj,
                     ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 4) == 0) ? 1 : 0);
            next_wait = GP;
            if (!enable) begin
                enable    = 1'b1;
                next_wait = GP + 1;
            end
        end

        // Reset pulse in the middle of a measurement
        k = 0;
        while (urf_start == '0 && k < next_wait + 4) begin
            tick();
            k++;
        end
        check("rst_pre_start", k, next_wait);
        repeat (3) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        model_reset();
        check_reset_outputs("midrst");
        run_slot(GP + 1, $urandom_range(1, TO - 1), 1'b1, RW'($urandom), 0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
